// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, error codes
// and the request fault classifier.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_BOUNDS   = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        RMW_WRITE = 2'd2,
        RESP      = 2'd3
    } lsu_state_t;

    // Priority: illegal funct3 > misalignment > out-of-bounds.
    function automatic logic [1:0] lsu_classify(input logic       write,
                                                input logic [2:0] f3,
                                                input logic [1:0] lo,
                                                input logic       oob);
        logic illegal;
        logic misalign;
        illegal  = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (write && f3[2]);
        misalign = ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
        if (illegal)       return ERR_FUNCT3;
        else if (misalign) return ERR_MISALIGN;
        else if (oob)      return ERR_BOUNDS;
        else               return ERR_OK;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory port bundle of the load/store unit.
// master = pipeline + memory side, slave = the load/store unit.
interface load_store_unit_if #(parameter int unsigned ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_address, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_address, mem_write_data
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension, and
// sub-word store merge into the previously read memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = word[{addr_lo, 3'b000} +: 8];
        half_lane  = word[{addr_lo[1], 4'b0000} +: 16];
        load_data  = word;
        store_word = wdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_BU:   load_data = {24'h000000, byte_lane};
            F3_HU:   load_data = {16'h0000, half_lane};
            default: load_data = word;
        endcase
        case (funct3)
            F3_B: begin
                store_word = word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                store_word = word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed memory without byte enables.
// Define LSU_BOUNDS_CHECK_EN to fault word indices >= MEM_WORDS with error code 11.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    lsu_state_t        state, state_next;
    logic              r_write;
    logic [2:0]        r_f3;
    logic [1:0]        r_lo;
    logic [31:0]       r_wdata;
    logic [1:0]        r_err;
    logic [ADDR_W-1:0] word_idx;
    logic              oob;
    logic [1:0]        req_err;
    logic              accept;
    logic              ready_c, resp_valid_c, mem_read_c, mem_write_c;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign word_idx = {2'b00, bus.req_addr[ADDR_W-1:2]};
    assign oob      = BOUNDS_EN && (word_idx >= ADDR_W'(MEM_WORDS));
    assign req_err  = lsu_classify(bus.req_write, bus.req_funct3, bus.req_addr[1:0], oob);
    assign accept   = bus.req_valid && ready_c;

    lsu_align u_align (
        .funct3     (r_f3),
        .addr_lo    (r_lo),
        .word       (bus.mem_read_data),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Faults still spend one quiet cycle in ACCESS so they share the 2-cycle load latency.
    always_comb begin
        state_next   = state;
        ready_c      = 1'b0;
        resp_valid_c = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) state_next = ACCESS;
            end
            ACCESS: begin
                state_next = RESP;
                if (r_err == ERR_OK) begin
                    if (!r_write) begin
                        mem_read_c = 1'b1;
                    end else if (r_f3 == F3_W) begin
                        mem_write_c = 1'b1;
                    end else begin
                        mem_read_c = 1'b1;
                        state_next = RMW_WRITE;
                    end
                end
            end
            RMW_WRITE: begin
                mem_write_c = 1'b1;
                state_next  = RESP;
            end
            RESP: begin
                resp_valid_c = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write            <= 1'b0;
            r_f3               <= '0;
            r_lo               <= '0;
            r_wdata            <= '0;
            r_err              <= ERR_OK;
            bus.resp_rdata     <= '0;
            bus.resp_err       <= ERR_OK;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
        end else begin
            if (accept) begin
                r_write <= bus.req_write;
                r_f3    <= bus.req_funct3;
                r_lo    <= bus.req_addr[1:0];
                r_wdata <= bus.req_wdata;
                r_err   <= req_err;
                if (req_err == ERR_OK) begin
                    bus.mem_address <= word_idx;
                    if (bus.req_write && (bus.req_funct3 == F3_W))
                        bus.mem_write_data <= bus.req_wdata;
                end
            end
            if (state == ACCESS) begin
                if (mem_read_c && r_write) begin
                    bus.mem_write_data <= store_word;
                end else begin
                    bus.resp_rdata <= (mem_read_c && !r_write) ? load_data : '0;
                    bus.resp_err   <= r_err;
                end
            end
            if (state == RMW_WRITE) begin
                bus.resp_rdata <= '0;
                bus.resp_err   <= ERR_OK;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases plus random
// traffic against a behavioural memory/response model; honours LSU_BOUNDS_CHECK_EN.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus();

    load_store_unit #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem     [0:2047];
    logic [31:0] ref_mem [0:2047];

    assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address[10:0]] : 32'hDEADBEEF;
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[10:0]] <= bus.mem_write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          active;
        int          accept;
        int          lat;
        bit          rd;
        bit          wr_first;
        bit          rmw;
        logic [31:0] idx;
        logic [31:0] wdata_exp;
        logic [31:0] rdata;
        logic [1:0]  err;
    } op_t;

    op_t         cur;
    bit          skip = 1'b0;
    logic [31:0] last_addr = '0;

    // Expected outcome of one request, straight from the RV32I access rules.
    function automatic void model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output op_t o);
        logic [31:0] word, b, h, nw;
        int sh, hs;
        o = '{default: 0};
        o.idx = a >> 2;
        word  = ref_mem[o.idx[10:0]];
        sh    = 8 * int'(a[1:0]);
        hs    = 16 * int'(a[1]);
        b     = (word >> sh) & 32'hFF;
        h     = (word >> hs) & 32'hFFFF;
        o.lat = 2;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (w && f3 >= 3'd4))
            o.err = 2'b10;
        else if (((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00))
            o.err = 2'b01;
`ifdef LSU_BOUNDS_CHECK_EN
        else if (o.idx >= 32'd1024)
            o.err = 2'b11;
`endif
        if (o.err == 2'b00) begin
            if (!w) begin
                o.rd = 1'b1;
                case (f3)
                    3'd0:    o.rdata = (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
                    3'd1:    o.rdata = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
                    3'd4:    o.rdata = b;
                    3'd5:    o.rdata = h;
                    default: o.rdata = word;
                endcase
            end else if (f3 == 3'd2) begin
                o.wr_first  = 1'b1;
                o.wdata_exp = wd;
                ref_mem[o.idx[10:0]] = wd;
            end else begin
                o.rd  = 1'b1;
                o.rmw = 1'b1;
                o.lat = 3;
                if (f3 == 3'd0) nw = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                else            nw = (word & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
                o.wdata_exp = nw;
                ref_mem[o.idx[10:0]] = nw;
            end
        end
    endfunction

    int k;
    always @(negedge clk) begin
        if (!skip && rst_n) begin
            if (cur.active && cyc >= cur.accept) begin
                k = cyc - cur.accept;
                chk1("req_ready_busy", bus.req_ready, 1'b0);
                if (k == 0) begin
                    chk1("mem_read_c1", bus.mem_read, cur.rd);
                    chk1("mem_write_c1", bus.mem_write, cur.wr_first);
                    if (cur.rd || cur.wr_first) begin
                        chk("mem_address_c1", bus.mem_address, cur.idx);
                        last_addr = bus.mem_address;
                    end
                    if (cur.wr_first) chk("mem_wdata_sw", bus.mem_write_data, cur.wdata_exp);
                    chk1("resp_valid_early", bus.resp_valid, 1'b0);
                end else if (k == 1 && cur.rmw) begin
                    chk1("mem_read_rmw", bus.mem_read, 1'b0);
                    chk1("mem_write_rmw", bus.mem_write, 1'b1);
                    chk("mem_address_rmw", bus.mem_address, cur.idx);
                    chk("mem_wdata_rmw", bus.mem_write_data, cur.wdata_exp);
                    chk1("resp_valid_early", bus.resp_valid, 1'b0);
                end
                if (k == cur.lat - 1) begin
                    chk1("resp_valid", bus.resp_valid, 1'b1);
                    chk("resp_rdata", bus.resp_rdata, cur.rdata);
                    chk("resp_err", {30'b0, bus.resp_err}, {30'b0, cur.err});
                    chk1("mem_read_resp", bus.mem_read, 1'b0);
                    chk1("mem_write_resp", bus.mem_write, 1'b0);
                    cur.active = 1'b0;
                end
            end else begin
                chk1("idle_resp_valid", bus.resp_valid, 1'b0);
                chk1("idle_mem_read", bus.mem_read, 1'b0);
                chk1("idle_mem_write", bus.mem_write, 1'b0);
                chk1("idle_req_ready", bus.req_ready, 1'b1);
            end
        end
    end

    task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        op_t o;
        int  n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
        end
        model(w, f3, a, wd, o);
        o.active = 1'b1;
        o.accept = cyc + 1;
        cur = o;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (cur.active && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (cur.active) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no resp_valid within %0d cycles, required %0d", n, o.lat);
            cur.active = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    logic [2:0]  rf3;
    logic [31:0] ra;
    int          sel;

    initial begin
        cur = '{default: 0};
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        mem[5]     = 32'h80FF7F01;
        ref_mem[5] = 32'h80FF7F01;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rst_req_ready", bus.req_ready, 1'b1);
        chk1("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_err", {30'b0, bus.resp_err}, 32'h0);
        chk1("rst_mem_read", bus.mem_read, 1'b0);
        chk1("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_mem_address", bus.mem_address, 32'h0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'h0);

        do_req(1'b0, 3'b010, 32'h14, 32'h0);
        chk("lit_lw", bus.resp_rdata, 32'h80FF7F01);
        chk("lit_lw_addr", last_addr, 32'd5);
        do_req(1'b0, 3'b000, 32'h17, 32'h0);
        chk("lit_lb", bus.resp_rdata, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h17, 32'h0);
        chk("lit_lbu", bus.resp_rdata, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h16, 32'h0);
        chk("lit_lh", bus.resp_rdata, 32'hFFFF80FF);
        do_req(1'b0, 3'b101, 32'h14, 32'h0);
        chk("lit_lhu", bus.resp_rdata, 32'h00007F01);
        do_req(1'b1, 3'b000, 32'h21, 32'h000000AB);
        chk("lit_sb_mem", mem[8], 32'h0000AB08);
        do_req(1'b0, 3'b010, 32'h20, 32'h0);
        chk("lit_lw_after_sb", bus.resp_rdata, 32'h0000AB08);
        do_req(1'b0, 3'b010, 32'h22, 32'h0);
        chk("lit_misalign", {30'b0, bus.resp_err}, 32'd1);
        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        chk("lit_funct3", {30'b0, bus.resp_err}, 32'd2);
        do_req(1'b0, 3'b010, 32'h1000, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
        chk("lit_bounds", {30'b0, bus.resp_err}, 32'd3);
`else
        chk("lit_nobounds_addr", last_addr, 32'h400);
`endif

        // Reset during the write half of an SH read-modify-write.
        @(negedge clk);
        skip = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h00005A5A;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk1("rst_sh_read", bus.mem_read, 1'b1);
        @(posedge clk);
        #1 chk1("rst_sh_write_pre", bus.mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_sh_write_drop", bus.mem_write, 1'b0);
        chk1("rst_sh_no_resp", bus.resp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sh_word12", mem[12], 32'h0000000C);
        chk1("rst_sh_no_resp2", bus.resp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk1("rst_sh_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        skip = 1'b0;
        do_req(1'b0, 3'b010, 32'h30, 32'h0);
        chk("rst_sh_readback", bus.resp_rdata, 32'h0000000C);

        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) ra = 32'h1000 + 32'($urandom_range(0, 1023));
            else          ra = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                rf3 = 3'($urandom_range(0, 7));
            end else begin
                case ($urandom_range(0, 4))
                    0:       rf3 = 3'b000;
                    1:       rf3 = 3'b001;
                    2:       rf3 = 3'b010;
                    3:       rf3 = 3'b100;
                    default: rf3 = 3'b101;
                endcase
            end
            if ($urandom_range(0, 3) != 0 && rf3 != 3'b000) ra[0] = 1'b0;
            if ($urandom_range(0, 3) != 0 && rf3 == 3'b010) ra[1] = 1'b0;
            do_req(1'($urandom_range(0, 1)), rf3, ra, $urandom);
        end

        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
